// File: rtl/hpi_txn_ctrl.sv
// HPI transaction sequencer: round-robin arbitration between two requesters,
// CS/RD/WR strobe timing toward the registered HPI I/O block, read-data capture.
module hpi_txn_ctrl #(
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  input  logic [15:0] hpi_data_in
);
  localparam int MAXC = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          cur;
  logic          t_we;
  logic          gnt_vld;
  logic          gnt_sel;

  // gnt_sel = 1 selects requester 1; on a tie the one not served last wins
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_sel = req1 & (~req0 | ~last_grant);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      cur          <= 1'b0;
      t_we         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      busy         <= 1'b0;
      hpi_address  <= '0;
      hpi_data_out <= '0;
      hpi_r        <= 1'b1;
      hpi_w        <= 1'b1;
      hpi_cs       <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            state        <= SETUP;
            busy         <= 1'b1;
            cur          <= gnt_sel;
            last_grant   <= gnt_sel;
            t_we         <= gnt_sel ? we1 : we0;
            hpi_address  <= gnt_sel ? addr1 : addr0;
            hpi_data_out <= gnt_sel ? wdata1 : wdata0;
            hpi_cs       <= 1'b0;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CW'(STROBE_CYCLES - 1);
          hpi_r <= t_we;
          hpi_w <= ~t_we;
        end
        STROBE: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= CW'(HOLD_CYCLES - 1);
            hpi_r <= 1'b1;
            hpi_w <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          // The I/O block returns pin data two cycles late, so the first HOLD
          // cycle carries what the pins showed in the last strobe cycle.
          if (cnt == CW'(HOLD_CYCLES - 1) && !t_we) rdata <= hpi_data_in;
          if (cnt == '0) begin
            state  <= RECOVER;
            hpi_cs <= 1'b1;
            ack0   <= ~cur;
            ack1   <= cur;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          hpi_r  <= 1'b1;
          hpi_w  <= 1'b1;
          hpi_cs <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hpi_txn_ctrl.sv
// Bench for hpi_txn_ctrl: directed vector table, arbitration/abort sequences,
// randomized traffic against a transaction-level model, and a parameter sweep.
module tb_hpi_txn_ctrl;
  localparam int S = 3, H = 1, L = 2 + S + H;

  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #5 Clk = ~Clk;

  logic        req[2], we[2];
  logic [1:0]  addr[2];
  logic [15:0] wdata[2];
  logic        ack0, ack1, busy, hpi_r, hpi_w, hpi_cs;
  logic [15:0] rdata, hpi_data_out, hpi_data_in;
  logic [1:0]  hpi_address;
  logic [15:0] mem[4];

  int n_chk = 0, n_pass = 0, viol = 0;

  hpi_txn_ctrl #(.STROBE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out),
    .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs), .hpi_data_in(hpi_data_in)
  );

  // interface block model: read data appears two cycles after hpi_r falls
  logic r_d1 = 1'b1, r_d2 = 1'b1;
  always @(posedge Clk) begin
    r_d1 <= hpi_r;
    r_d2 <= r_d1;
  end
  assign hpi_data_in = r_d2 ? 16'hDEAD : mem[hpi_address];

  always @(negedge Clk)
    if (Reset_N && ((!hpi_r && !hpi_w) || (hpi_cs && !(hpi_r && hpi_w)))) viol++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    for (int i = 0; i < 2; i++) req[i] = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_N = 1'b1;
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int c = 1; c <= 3 * L; c++) begin
      @(posedge Clk); #1;
      if (ack0 || ack1) begin
        who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        cyc = c;
        break;
      end
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl[6];

  task automatic run_txn(input int k, input vec_t v);
    int n_ack, nacks, other, sl, osl, csl, nbusy, bad_bus;
    logic [15:0] rd_at_ack;
    n_ack = -1; nacks = 0; other = 0; sl = 0; osl = 0; csl = 0; nbusy = 0; bad_bus = 0;
    rd_at_ack = 16'hxxxx;
    req[v.port] = 1'b1; we[v.port] = v.we; addr[v.port] = v.addr; wdata[v.port] = v.wdata;
    for (int c = 1; c <= L + 4; c++) begin
      @(posedge Clk); #1;
      if (!hpi_cs) begin
        csl++;
        if (hpi_address !== v.addr || (v.we && hpi_data_out !== v.wdata)) bad_bus++;
      end
      if ((v.we ? hpi_w : hpi_r) == 1'b0) sl++;
      if ((v.we ? hpi_r : hpi_w) == 1'b0) osl++;
      if (busy) nbusy++;
      if (v.port == 1 ? ack0 : ack1) other++;
      if (v.port == 1 ? ack1 : ack0) begin
        nacks++;
        if (n_ack < 0) begin
          n_ack = c;
          rd_at_ack = rdata;
          req[v.port] = 1'b0;
        end
      end
    end
    chk($sformatf("v%0d_ack_cycle", k), n_ack, L);
    chk($sformatf("v%0d_ack_count", k), nacks, 1);
    chk($sformatf("v%0d_other_ack", k), other, 0);
    chk($sformatf("v%0d_strobe_width", k), sl, S);
    chk($sformatf("v%0d_other_strobe", k), osl, 0);
    chk($sformatf("v%0d_cs_width", k), csl, 1 + S + H);
    chk($sformatf("v%0d_busy_cycles", k), nbusy, L);
    chk($sformatf("v%0d_bus_stable", k), bad_bus, 0);
    chk($sformatf("v%0d_rdata", k), rd_at_ack, v.exp_rdata);
  endtask

  // parameter sweep: two extra builds, each running one write and one read
  for (genvar c = 0; c < 2; c++) begin : g_sw
    localparam int SS = (c == 0) ? 2 : 5;
    localparam int HH = 2;
    localparam logic [15:0] RDV = (c == 0) ? 16'h7E57 : 16'h57E7;
    logic rn = 1'b0, rq = 1'b0, swe = 1'b0;
    logic [1:0] sad = 2'd0;
    logic [15:0] swd = 16'h0;
    logic sa0, sa1, sbusy, sr, sw, scs;
    logic [15:0] srd, sdo, sdi;
    logic [1:0] saddr;
    logic d1 = 1'b1, d2 = 1'b1;
    int res[11], exp_res[11];
    int lviol = 0;
    int ac, sl, ol, cl;

    always @(posedge Clk) begin
      d1 <= sr;
      d2 <= d1;
    end
    assign sdi = d2 ? 16'hDEAD : RDV;
    always @(negedge Clk) if (rn && ((!sr && !sw) || (scs && !(sr && sw)))) lviol++;

    hpi_txn_ctrl #(.STROBE_CYCLES(SS), .HOLD_CYCLES(HH)) u_sw (
      .Clk(Clk), .Reset_N(rn),
      .req0(rq), .we0(swe), .addr0(sad), .wdata0(swd),
      .req1(1'b0), .we1(1'b0), .addr1(2'b00), .wdata1(16'h0000),
      .ack0(sa0), .ack1(sa1), .rdata(srd), .busy(sbusy),
      .hpi_address(saddr), .hpi_data_out(sdo),
      .hpi_r(sr), .hpi_w(sw), .hpi_cs(scs), .hpi_data_in(sdi)
    );

    initial begin
      exp_res = '{2 + SS + HH, SS, 0, 1 + SS + HH, 2 + SS + HH, SS, 0, 1 + SS + HH, int'(RDV), 0, 1};
      for (int k = 0; k < 11; k++) res[k] = -1;
      res[10] = 0;
      repeat (3) @(posedge Clk);
      @(negedge Clk) rn = 1'b1;
      for (int t = 0; t < 2; t++) begin
        ac = -1; sl = 0; ol = 0; cl = 0;
        swe = (t == 0); sad = (t == 0) ? 2'd1 : 2'd3; swd = 16'h5A5A; rq = 1'b1;
        for (int cy = 1; cy <= 2 + SS + HH + 3; cy++) begin
          @(posedge Clk); #1;
          if (!scs) cl++;
          if ((swe ? sw : sr) == 1'b0) sl++;
          if ((swe ? sr : sw) == 1'b0) ol++;
          if (sa0 && ac < 0) begin
            ac = cy;
            rq = 1'b0;
          end
        end
        res[4*t+0] = ac; res[4*t+1] = sl; res[4*t+2] = ol; res[4*t+3] = cl;
      end
      res[8]  = int'(srd);
      res[9]  = lviol;
      res[10] = 1;
    end
  end

  // transaction-level reference model state
  int   ph, g, lg, cool[2];
  logic twe;
  logic [1:0] taddr;
  logic [15:0] twdata, erd;
  logic e_busy, e_cs, e_r, e_w, e_a0, e_a1;

  initial begin
    int who, cyc, n0, n1;
    mem = '{16'h1234, 16'hA5A5, 16'h0F0F, 16'hC3C3};
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 2'd0; wdata[i] = 16'h0; cool[i] = 0;
    end
    tbl[0] = '{0, 1'b1, 2'd2, 16'hBEEF, 16'h0000};
    tbl[1] = '{1, 1'b0, 2'd0, 16'h0000, 16'h1234};
    tbl[2] = '{0, 1'b0, 2'd3, 16'h7777, 16'hC3C3};
    tbl[3] = '{1, 1'b1, 2'd1, 16'h0001, 16'hC3C3};
    tbl[4] = '{0, 1'b0, 2'd1, 16'hFFFF, 16'hA5A5};
    tbl[5] = '{1, 1'b1, 2'd3, 16'hFFFF, 16'hA5A5};

    do_reset();
    chk("reset_state", {hpi_r, hpi_w, hpi_cs, busy, ack0, ack1, hpi_address, hpi_data_out, rdata},
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0});

    for (int k = 0; k < 6; k++) run_txn(k, tbl[k]);

    // simultaneous requests after reset: 0, then 1, then a new pair goes to 0
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2'd0; wdata[0] = 16'h1111;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 2'd2; wdata[1] = 16'h2222;
    wait_ack(who, cyc);
    chk("arb_first_who", who, 0);
    chk("arb_first_cycle", cyc, L);
    chk("arb_first_rdata", rdata, 16'h0000);
    req[0] = 1'b0;
    wait_ack(who, cyc);
    chk("arb_second_who", who, 1);
    chk("arb_second_rdata", rdata, 16'h0F0F);
    req[1] = 1'b0;
    @(posedge Clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 2'd1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 2'd3;
    wait_ack(who, cyc);
    chk("arb_pair2_who", who, 0);
    chk("arb_pair2_rdata", rdata, 16'hA5A5);
    req[0] = 1'b0;
    wait_ack(who, cyc);
    chk("arb_pair2_next", who, 1);
    req[1] = 1'b0;

    // req dropped during STROBE still completes exactly once
    @(posedge Clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 2'd3;
    repeat (3) @(posedge Clk); #1;
    chk("drop_in_strobe_r", hpi_r, 1'b0);
    req[0] = 1'b0;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 3 * L; c++) begin
      @(posedge Clk); #1;
      if (ack0) n0++;
      if (ack1) n1++;
    end
    chk("drop_ack0_count", n0, 1);
    chk("drop_ack1_count", n1, 0);
    chk("drop_rdata", rdata, 16'hC3C3);
    chk("drop_idle_busy", busy, 1'b0);

    // reset during the STROBE of a read
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 2'd1;
    repeat (3) @(posedge Clk); #1;
    chk("abort_pre_r", hpi_r, 1'b0);
    #2 Reset_N = 1'b0;
    #1;
    chk("abort_outputs", {hpi_r, hpi_w, hpi_cs, busy, ack0, ack1, rdata},
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    req[1] = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_N = 1'b1;
    n0 = 0;
    for (int c = 0; c < 2 * L; c++) begin
      @(posedge Clk); #1;
      if (ack0 || ack1 || busy) n0++;
    end
    chk("abort_no_ack", n0, 0);

    // randomized traffic against the transaction model
    Reset_N = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
    do_reset();
    ph = 0; g = 0; lg = 1; twe = 1'b0; taddr = 2'd0; twdata = 16'h0; erd = 16'h0;
    for (int cy = 0; cy < 1500; cy++) begin
      if (ph == 0) begin
        if (req[0] || req[1]) begin
          g = (req[0] && req[1]) ? 1 - lg : (req[0] ? 0 : 1);
          lg = g;
          twe = we[g]; taddr = addr[g]; twdata = wdata[g];
          ph = 1;
        end
      end else begin
        if (ph == S + 2 && !twe) erd = mem[taddr];
        ph = (ph == L) ? 0 : ph + 1;
      end
      @(posedge Clk); #1;
      e_busy = (ph != 0);
      e_cs   = !(ph >= 1 && ph <= L - 1);
      e_r    = !(!twe && ph >= 2 && ph <= S + 1);
      e_w    = !(twe && ph >= 2 && ph <= S + 1);
      e_a0   = (ph == L && g == 0);
      e_a1   = (ph == L && g == 1);
      chk($sformatf("rand_ctl_c%0d", cy), {ack0, ack1, busy, hpi_cs, hpi_r, hpi_w},
          {e_a0, e_a1, e_busy, e_cs, e_r, e_w});
      chk($sformatf("rand_rdata_c%0d", cy), rdata, erd);
      if (ph >= 1 && ph <= L - 1)
        chk($sformatf("rand_bus_c%0d", cy), {hpi_address, hpi_data_out}, {taddr, twdata});
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ((i == 0) ? e_a0 : e_a1)) begin
          req[i] = 1'b0;
          cool[i] = $urandom_range(1, 3);
        end else if (!req[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1; we[i] = 1'($urandom); addr[i] = 2'($urandom); wdata[i] = 16'($urandom);
          end
        end else if (ph != 0 && g == i) begin
          if ($urandom_range(0, 3) == 0) begin
            we[i] = 1'($urandom); addr[i] = 2'($urandom); wdata[i] = 16'($urandom);
          end
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end
      end
    end

    for (int k = 0; k < 11; k++) begin
      chk($sformatf("sweep_s2_%0d", k), g_sw[0].res[k], g_sw[0].exp_res[k]);
      chk($sformatf("sweep_s5_%0d", k), g_sw[1].res[k], g_sw[1].exp_res[k]);
    end
    chk("protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
